// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: per-channel shadow/active divisor, tick strobe and 50% square wave.
// Optional macro PROG_CLK_DIVIDER_SYNC_EN adds i_sync to restart every channel phase-aligned.
module prog_clk_divider #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned WIDTH       = 25,
   parameter int unsigned DEFAULT_DIV = 1
) (
   input  logic                i_clkPin,
   input  logic                i_rstPin,
   input  logic                i_ena,
   input  logic [CHANNELS-1:0] i_chEna,
   input  logic                i_wrEn,
   input  logic [3:0]          i_wrChan,
   input  logic [WIDTH-1:0]    i_wrData,
`ifdef PROG_CLK_DIVIDER_SYNC_EN
   input  logic                i_sync,
`endif
   output logic [CHANNELS-1:0] o_clkPin,
   output logic [CHANNELS-1:0] o_tick
);

   localparam logic [WIDTH-1:0] LP_DEF = WIDTH'(DEFAULT_DIV);

   logic w_sync;
`ifdef PROG_CLK_DIVIDER_SYNC_EN
   assign w_sync = i_sync;
`else
   assign w_sync = 1'b0;
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [WIDTH-1:0] r_shadow;
      logic [WIDTH-1:0] r_active;
      logic [WIDTH-1:0] r_cnt;
      logic             r_clk;
      logic             r_tick;
      logic             w_wrHit;
      logic             w_term;

      // Indices at or above CHANNELS never match any channel, so such writes are dropped.
      assign w_wrHit = i_wrEn && (i_wrChan == 4'(g));
      assign w_term  = (r_cnt == r_active);

      always_ff @(posedge i_clkPin or posedge i_rstPin) begin
         if (i_rstPin) begin
            r_shadow <= LP_DEF;
         end else if (w_wrHit) begin
            r_shadow <= i_wrData;
         end
      end

      always_ff @(posedge i_clkPin or posedge i_rstPin) begin
         if (i_rstPin) begin
            r_active <= LP_DEF;
            r_cnt    <= '0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
         end else if (w_sync || !i_chEna[g]) begin
            r_active <= r_shadow;
            r_cnt    <= '0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
         end else if (!i_ena) begin
            r_tick   <= 1'b0;
         end else if (w_term) begin
            // A write landing on the terminal count bypasses the shadow.
            r_active <= w_wrHit ? i_wrData : r_shadow;
            r_cnt    <= '0;
            r_clk    <= ~r_clk;
            r_tick   <= 1'b1;
         end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_tick   <= 1'b0;
         end
      end

      assign o_clkPin[g] = r_clk;
      assign o_tick[g]   = r_tick;
   end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: directed scenarios plus random traffic against a countdown model.
module tb_prog_clk_divider;
   localparam int unsigned CH  = 4;
   localparam int unsigned W   = 8;
   localparam int unsigned DEF = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic [CH-1:0] chEna;
   logic          wrEn;
   logic [3:0]    wrChan;
   logic [W-1:0]  wrData;
   logic          sync;
   logic [CH-1:0] o_clk;
   logic [CH-1:0] o_tick;

   int vectors     = 0;
   int miscompares = 0;

   prog_clk_divider #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
      .i_clkPin (clk),
      .i_rstPin (rst),
      .i_ena    (ena),
      .i_chEna  (chEna),
      .i_wrEn   (wrEn),
      .i_wrChan (wrChan),
      .i_wrData (wrData),
`ifdef PROG_CLK_DIVIDER_SYNC_EN
      .i_sync   (sync),
`endif
      .o_clkPin (o_clk),
      .o_tick   (o_tick)
   );

   always #5 clk = ~clk;

   // Model: each channel counts down the enabled cycles left until its next tick.
   int unsigned   m_shadow [CH];
   int unsigned   m_active [CH];
   int unsigned   m_left   [CH];
   logic [CH-1:0] m_clk;
   logic [CH-1:0] m_tick;

   function automatic void model_reset();
      for (int unsigned c = 0; c < CH; c++) begin
         m_shadow[c] = DEF;
         m_active[c] = DEF;
         m_left[c]   = DEF + 1;
      end
      m_clk  = '0;
      m_tick = '0;
   endfunction

   function automatic void model_step();
      int unsigned old_sh [CH];
      bit hit;
      for (int unsigned c = 0; c < CH; c++) old_sh[c] = m_shadow[c];
      for (int unsigned c = 0; c < CH; c++) begin
         hit = wrEn && (int'(wrChan) == int'(c));
         if (sync || !chEna[c]) begin
            m_active[c] = old_sh[c];
            m_left[c]   = m_active[c] + 1;
            m_clk[c]    = 1'b0;
            m_tick[c]   = 1'b0;
         end else if (!ena) begin
            m_tick[c] = 1'b0;
         end else begin
            m_left[c] = m_left[c] - 1;
            if (m_left[c] == 0) begin
               m_tick[c]   = 1'b1;
               m_clk[c]    = ~m_clk[c];
               m_active[c] = hit ? int'(wrData) : old_sh[c];
               m_left[c]   = m_active[c] + 1;
            end else begin
               m_tick[c] = 1'b0;
            end
         end
         if (hit) m_shadow[c] = int'(wrData);
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      check("tick", 32'(o_tick), 32'(m_tick));
      check("clkPin", 32'(o_clk), 32'(m_clk));
   endtask

   task automatic wait_tick(input int ch, input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!o_tick[ch] && n < budget);
      if (!o_tick[ch]) check("tick_timeout", 32'(o_tick[ch]), 32'd1);
   endtask

   task automatic wr(input int ch, input int unsigned d);
      wrEn   = 1'b1;
      wrChan = 4'(ch);
      wrData = W'(d);
      step();
      wrEn   = 1'b0;
   endtask

   initial begin
      int n;
      int cnt;
      logic [CH-1:0] saved;
      int first [CH];

      rst = 1'b1; ena = 1'b1; chEna = '1; wrEn = 1'b0; wrChan = '0; wrData = '0; sync = 1'b0;
      model_reset();
      #1;
      check("reset_tick", 32'(o_tick), 32'(m_tick));
      check("reset_clk", 32'(o_clk), 32'(m_clk));
      step();
      step();
      @(negedge clk);
      rst = 1'b0;

      // Default divisor: tick every 2 cycles on every channel.
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (o_tick[0]) cnt++;
      end
      check("def_ticks_in_8", 32'(cnt), 32'd4);

      // Write on the terminal-count cycle loads the active divisor directly.
      wait_tick(0, 10, n);
      step();
      wrEn = 1'b1; wrChan = 4'd0; wrData = 8'd7;
      step();
      wrEn = 1'b0;
      check("wr_at_term_tick", 32'(o_tick[0]), 32'd1);
      wait_tick(0, 20, n);
      check("wr_at_term_period", 32'(n), 32'd8);

      // Lowering D mid-period only applies after the current period.
      wr(2, 9);
      wait_tick(2, 20, n);
      wait_tick(2, 20, n);
      repeat (5) step();
      wr(2, 3);
      wait_tick(2, 20, n);
      check("lower_d_first", 32'(n + 6), 32'd10);
      wait_tick(2, 20, n);
      check("lower_d_next", 32'(n), 32'd4);

      // Global hold mid-period freezes everything.
      wr(1, 4);
      wait_tick(1, 20, n);
      wait_tick(1, 20, n);
      repeat (2) step();
      saved = o_clk;
      ena = 1'b0;
      repeat (5) begin
         step();
         check("hold_tick_low", 32'(o_tick), 32'd0);
      end
      check("hold_clk_frozen", 32'(o_clk), 32'(saved));
      ena = 1'b1;
      wait_tick(1, 20, n);
      check("hold_resume", 32'(n), 32'd3);

      // Out-of-range channel write is ignored.
      wr(6, 0);
      wait_tick(0, 20, n);
      wait_tick(0, 20, n);
      check("bad_chan_period", 32'(n), 32'd8);

      // Full-scale divisor on an 8-bit counter.
      wr(3, 255);
      wait_tick(3, 600, n);
      wait_tick(3, 600, n);
      wait_tick(3, 600, n);
      check("max_d_period", 32'(n), 32'd256);

      // Asynchronous reset mid-period.
      repeat (3) step();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rst_tick", 32'(o_tick), 32'(m_tick));
      check("async_rst_clk", 32'(o_clk), 32'(m_clk));
      step();
      @(negedge clk);
      rst = 1'b0;
      wait_tick(0, 10, n);
      check("post_rst_first", 32'(n), 32'(DEF + 1));

`ifdef PROG_CLK_DIVIDER_SYNC_EN
      wr(0, 2);
      wr(1, 3);
      wr(2, 5);
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync_clk_low", 32'(o_clk), 32'd0);
      for (int c = 0; c < int'(CH); c++) first[c] = 0;
      for (int k = 1; k <= 6; k++) begin
         step();
         for (int c = 0; c < 3; c++)
            if (o_tick[c] && first[c] == 0) first[c] = k;
      end
      check("sync_first0", 32'(first[0]), 32'd3);
      check("sync_first1", 32'(first[1]), 32'd4);
      check("sync_first2", 32'(first[2]), 32'd6);
`else
      for (int c = 0; c < int'(CH); c++) first[c] = 0;
`endif

      // Random traffic against the model.
      repeat (400) begin
         ena    = ($urandom_range(0, 9) != 0);
         chEna  = ~(CH'($urandom) & CH'($urandom) & CH'($urandom) & CH'($urandom));
         wrEn   = ($urandom_range(0, 3) == 0);
         wrChan = 4'($urandom_range(0, 7));
         wrData = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
